ir_tx_encoder: RTL

Pulse-distance IR frame encoder sitting directly downstream of the 97.656 kHz clock generator. It runs on the 100 MHz system clock and uses the divided clock only as a timing reference: each synchronised rising edge is one tick of 10.24 µs. It serialises a parallel data word into an NEC-style envelope of header mark/space, per-bit mark/space and a stop mark. `ir_o` is the unmodulated envelope; carrier modulation is done by the downstream driver stage.

---
 rtl/ir_tx_encoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ir_tx_encoder.sv
// Pulse-distance (NEC-style) IR envelope encoder. Timing comes from rising
// edges of a slow reference clock, synchronised into single-cycle ticks.
module ir_tx_encoder #(
   parameter int DATA_W     = 32,
   parameter int HDR_MARK   = 879,
   parameter int HDR_SPACE  = 439,
   parameter int BIT_MARK   = 55,
   parameter int ZERO_SPACE = 55,
   parameter int ONE_SPACE  = 165,
   parameter int CNT_W      = 10
) (
   input  logic              clk_i,
   input  logic              rst,
   input  logic              clk_ref_i,
   input  logic              send_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              ready_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              ir_o
);

   localparam int IDX_W = $clog2(DATA_W + 1);

   localparam logic [CNT_W-1:0] HDR_M_LAST = CNT_W'(HDR_MARK - 1);
   localparam logic [CNT_W-1:0] HDR_S_LAST = CNT_W'(HDR_SPACE - 1);
   localparam logic [CNT_W-1:0] BIT_M_LAST = CNT_W'(BIT_MARK - 1);
   localparam logic [CNT_W-1:0] ZERO_LAST  = CNT_W'(ZERO_SPACE - 1);
   localparam logic [CNT_W-1:0] ONE_LAST   = CNT_W'(ONE_SPACE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_HDR_M,
      S_HDR_S,
      S_BIT_M,
      S_BIT_S,
      S_STOP_M
   } state_t;

   state_t            state;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_d;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_d;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_d;

   logic s1;
   logic s2;
   logic s3;
   logic tick;
   logic phase_last;
   logic ir_d;

   // clk_ref_i is asynchronous to clk_i: two sync flops, then an edge detector.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= clk_ref_i;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign tick = s2 & ~s3;

   // State register: FSM state plus the phase counter, bit index and payload.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         idx   <= idx_d;
         shreg <= shreg_d;
      end
   end

   // Space length of a bit is chosen by the payload MSB still in the register.
   always_comb begin
      phase_last = 1'b0;
      case (state)
         S_HDR_M:  phase_last = (cnt == HDR_M_LAST);
         S_HDR_S:  phase_last = (cnt == HDR_S_LAST);
         S_BIT_M:  phase_last = (cnt == BIT_M_LAST);
         S_BIT_S:  phase_last = shreg[DATA_W-1] ? (cnt == ONE_LAST) : (cnt == ZERO_LAST);
         S_STOP_M: phase_last = (cnt == BIT_M_LAST);
         default:  phase_last = 1'b0;
      endcase
   end

   // Handshake: a request is taken on any clk_i edge where send_i=1 and
   // ready_o=1; data_i is captured on that edge. send_i is ignored otherwise.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      shreg_d = shreg;
      case (state)
         S_IDLE: begin
            if (send_i) begin
               state_d = S_ARM;
               shreg_d = data_i;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         S_ARM: begin
            if (tick) begin
               state_d = S_HDR_M;
               cnt_d   = '0;
            end
         end
         default: begin
            if (tick) begin
               if (phase_last) begin
                  cnt_d = '0;
                  case (state)
                     S_HDR_M: state_d = S_HDR_S;
                     S_HDR_S: state_d = S_BIT_M;
                     S_BIT_M: state_d = S_BIT_S;
                     S_BIT_S: begin
                        shreg_d = shreg << 1;
                        idx_d   = idx + 1'b1;
                        state_d = (idx == IDX_LAST) ? S_STOP_M : S_BIT_M;
                     end
                     default: state_d = S_IDLE;
                  endcase
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
         end
      endcase
   end

   // Outputs: done_o coincides with the tick that ends the stop mark.
   always_comb begin
      ready_o = (state == S_IDLE);
      busy_o  = (state != S_IDLE);
      done_o  = (state == S_STOP_M) && tick && phase_last;
      ir_d    = (state == S_HDR_M) || (state == S_BIT_M) || (state == S_STOP_M);
   end

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         ir_o <= 1'b0;
      end else begin
         ir_o <= ir_d;
      end
   end

endmodule
